// File: rtl/uart_tx_pkg.sv
// Shared UART TX definitions: FSM state encoding and the TX line mux select codes.
// The downstream line mux uses the same SEL_* constants, so both sides agree on every code.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   localparam logic [2:0] SEL_IDLE  = 3'b000;
   localparam logic [2:0] SEL_START = 3'b001;
   localparam logic [2:0] SEL_DATA  = 3'b010;
   localparam logic [2:0] SEL_PAR   = 3'b011;
   localparam logic [2:0] SEL_STOP  = 3'b100;

   function automatic logic [2:0] sel_of_state(input state_t s);
      logic [2:0] sel;
      sel = SEL_IDLE;
      case (s)
         ST_IDLE:   sel = SEL_IDLE;
         ST_START:  sel = SEL_START;
         ST_DATA:   sel = SEL_DATA;
         ST_PARITY: sel = SEL_PAR;
         ST_STOP:   sel = SEL_STOP;
         default:   sel = SEL_IDLE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Request/status bundle between a payload source (master) and the UART TX controller (slave).
interface uart_tx_ctrl_if #(parameter int DATA_WIDTH = 8);

   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  DATA_VALID;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic [2:0]            MUX_SEL;
   logic                  SER_DATA;
   logic                  PAR_BIT;
   logic                  BUSY;

   modport master (
      output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
      input  MUX_SEL, SER_DATA, PAR_BIT, BUSY
   );

   modport slave (
      input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
      output MUX_SEL, SER_DATA, PAR_BIT, BUSY
   );

endinterface

// File: rtl/uart_tx_serializer.sv
// Payload shift register (LSB first) with a data-bit counter; o_done flags the last data bit.
module uart_tx_serializer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_load,
   input  logic                  i_shift_en,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_bit,
   output logic                  o_done
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] r_shift;
   logic [CNT_W-1:0]      r_cnt;
   logic                  w_last;

   assign w_last = (r_cnt == LAST_IDX);

   // Counter parks on the last index instead of wrapping; the next load clears it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (i_load) begin
         r_shift <= i_data;
         r_cnt   <= '0;
      end else if (i_shift_en) begin
         r_shift <= r_shift >> 1;
         if (!w_last) r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_bit  = r_shift[0];
   assign o_done = i_shift_en && w_last;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame controller: START, DATA_WIDTH data bits, optional PARITY, STOP; drives the line mux select.
// Parity support is built only when the macro UART_TX_PARITY_EN is defined.
module uart_tx_ctrl
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic          CLK,
   input  logic          RST,
   uart_tx_ctrl_if.slave bus
);

   state_t r_state;
   state_t w_next;
   logic   w_load;
   logic   w_shift_en;
   logic   w_ser_bit;
   logic   w_done;
   logic   w_par_en;
   logic   w_par_bit;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) r_state <= ST_IDLE;
      else      r_state <= w_next;
   end

   // A new request is accepted only from IDLE or STOP; other states drop DATA_VALID.
   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.DATA_VALID) begin
               w_next = ST_START;
               w_load = 1'b1;
            end
         end
         ST_START:  w_next = ST_DATA;
         ST_DATA: begin
            if (w_done) w_next = w_par_en ? ST_PARITY : ST_STOP;
         end
         ST_PARITY: w_next = ST_STOP;
         ST_STOP: begin
            if (bus.DATA_VALID) begin
               w_next = ST_START;
               w_load = 1'b1;
            end else begin
               w_next = ST_IDLE;
            end
         end
         default:   w_next = ST_IDLE;
      endcase
   end

   assign w_shift_en = (r_state == ST_DATA);

   uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
      .i_clk      (CLK),
      .i_rst_n    (RST),
      .i_load     (w_load),
      .i_shift_en (w_shift_en),
      .i_data     (bus.P_DATA),
      .o_bit      (w_ser_bit),
      .o_done     (w_done)
   );

`ifdef UART_TX_PARITY_EN
   logic r_par_en;
   logic r_par_bit;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_par_en  <= 1'b0;
         r_par_bit <= 1'b0;
      end else if (w_load) begin
         r_par_en  <= bus.PAR_EN;
         r_par_bit <= (^bus.P_DATA) ^ bus.PAR_TYP;
      end
   end

   assign w_par_en  = r_par_en;
   assign w_par_bit = r_par_bit;
`else
   logic w_unused_par;
   assign w_unused_par = bus.PAR_EN ^ bus.PAR_TYP;
   assign w_par_en     = 1'b0;
   assign w_par_bit    = 1'b0;
`endif

   assign bus.MUX_SEL  = sel_of_state(r_state);
   assign bus.SER_DATA = w_shift_en & w_ser_bit;
   assign bus.PAR_BIT  = w_par_bit;
   assign bus.BUSY     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: stimulus queues expected per-cycle outputs, a negedge monitor compares.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
   localparam bit PAR_BUILD = 1'b1;
`else
   localparam bit PAR_BUILD = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RST = 1'b0;

   always #5 CLK = ~CLK;

   uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus();

   uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   typedef struct {
      string      tag;
      logic [5:0] v;
   } exp_t;

   exp_t exp_q[$];
   exp_t m_e;
   int   n_checks = 0;
   int   n_errors = 0;
   logic par_hold = 1'b0;

   function automatic logic [5:0] pack(input logic [2:0] sel, input logic ser,
                                       input logic par, input logic busy);
      return {sel, ser, par, busy};
   endfunction

   function automatic logic [5:0] dut_out();
      return pack(bus.MUX_SEL, bus.SER_DATA, bus.PAR_BIT, bus.BUSY);
   endfunction

   task automatic check(input string tag, input logic [5:0] act, input logic [5:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got sel=%b ser=%b par=%b busy=%b, expected sel=%b ser=%b par=%b busy=%b",
                  tag, act[5:3], act[2], act[1], act[0], exp[5:3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic push(input string tag, input logic [5:0] v);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      exp_q.push_back(e);
   endtask

   task automatic push_idle(input int n, input logic par);
      for (int i = 0; i < n; i++) push("idle", pack(3'b000, 1'b0, par, 1'b0));
   endtask

   task automatic push_frame(input string tag, input logic [7:0] d,
                             input logic with_par, input logic par);
      push({tag, ":start"}, pack(3'b001, 1'b0, par, 1'b1));
      for (int i = 0; i < 8; i++)
         push($sformatf("%s:d%0d", tag, i), pack(3'b010, d[i], par, 1'b1));
      if (with_par) push({tag, ":parity"}, pack(3'b011, 1'b0, par, 1'b1));
      push({tag, ":stop"}, pack(3'b100, 1'b0, par, 1'b1));
   endtask

   // Monitor: every cycle with an outstanding expectation is compared mid-cycle.
   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         m_e = exp_q.pop_front();
         check(m_e.tag, dut_out(), m_e.v);
      end
   end

   task automatic drain();
      int budget = 200;
      while (exp_q.size() > 0 && budget > 0) begin
         @(posedge CLK);
         budget--;
      end
      if (exp_q.size() > 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
         exp_q.delete();
      end
      #2;
   endtask

   // Called at posedge+2 with the DUT idle; par_hand is the hand-computed parity bit.
   task automatic send(input string tag, input logic [7:0] d, input logic pen,
                       input logic ptyp, input logic par_hand, input int n_idle);
      logic p;
      p = PAR_BUILD & par_hand;
      bus.P_DATA     = d;
      bus.PAR_EN     = pen;
      bus.PAR_TYP    = ptyp;
      bus.DATA_VALID = 1'b1;
      push_idle(1, par_hold);
      push_frame(tag, d, PAR_BUILD & pen, p);
      push_idle(n_idle, p);
      par_hold = p;
      @(posedge CLK);
      #2 bus.DATA_VALID = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      bus.P_DATA     = '0;
      bus.DATA_VALID = 1'b0;
      bus.PAR_EN     = 1'b0;
      bus.PAR_TYP    = 1'b0;
      #1 check("reset_state", dut_out(), pack(3'b000, 1'b0, 1'b0, 1'b0));
      repeat (3) @(posedge CLK);
      #2 RST = 1'b1;
      @(posedge CLK);
      #2;

      // A5 without parity: 1,0,1,0,0,1,0,1 then STOP, 10 busy cycles
      send("a5_nopar", 8'hA5, 1'b0, 1'b0, 1'b0, 2);
      drain();

      // A5 even parity (0) and odd parity (1); parity-less build gives 10-cycle frames, PAR_BIT 0
      send("a5_even", 8'hA5, 1'b1, 1'b0, 1'b0, 2);
      drain();
      send("a5_odd", 8'hA5, 1'b1, 1'b1, 1'b1, 2);
      drain();

      // Back-to-back: 01 then FF with DATA_VALID held; P_DATA change mid-frame must not disturb frame 1
      bus.P_DATA     = 8'h01;
      bus.PAR_EN     = 1'b0;
      bus.PAR_TYP    = 1'b0;
      bus.DATA_VALID = 1'b1;
      push_idle(1, par_hold);
      push_frame("b2b_01", 8'h01, 1'b0, PAR_BUILD & 1'b1);
      push_frame("b2b_ff", 8'hFF, 1'b0, 1'b0);
      push_idle(2, 1'b0);
      par_hold = 1'b0;
      @(posedge CLK);
      #2 bus.P_DATA = 8'hFF;
      repeat (10) @(posedge CLK);
      #2 bus.DATA_VALID = 1'b0;
      drain();

      // Request pulse with 3C during DATA is dropped; only the C3 frame appears
      bus.P_DATA     = 8'hC3;
      bus.PAR_EN     = 1'b0;
      bus.PAR_TYP    = 1'b0;
      bus.DATA_VALID = 1'b1;
      push_idle(1, par_hold);
      push_frame("c3", 8'hC3, 1'b0, 1'b0);
      push_idle(4, 1'b0);
      par_hold = 1'b0;
      @(posedge CLK);
      #2 bus.DATA_VALID = 1'b0;
      repeat (3) @(posedge CLK);
      #2 begin
         bus.DATA_VALID = 1'b1;
         bus.P_DATA     = 8'h3C;
         bus.PAR_EN     = 1'b1;
      end
      @(posedge CLK);
      #2 begin
         bus.DATA_VALID = 1'b0;
         bus.PAR_EN     = 1'b0;
      end
      drain();

      // Reset asserted during the 4th data bit of a 0F frame
      bus.P_DATA     = 8'h0F;
      bus.DATA_VALID = 1'b1;
      push_idle(1, par_hold);
      push("rst:start", pack(3'b001, 1'b0, 1'b0, 1'b1));
      for (int i = 0; i < 3; i++) push($sformatf("rst:d%0d", i), pack(3'b010, 1'b1, 1'b0, 1'b1));
      @(posedge CLK);
      #2 bus.DATA_VALID = 1'b0;
      repeat (4) @(posedge CLK);
      #2 RST = 1'b0;
      #1 check("rst_async", dut_out(), pack(3'b000, 1'b0, 1'b0, 1'b0));
      @(posedge CLK);
      #2 check("rst_hold", dut_out(), pack(3'b000, 1'b0, 1'b0, 1'b0));
      RST      = 1'b1;
      par_hold = 1'b0;
      @(posedge CLK);
      #2;
      push_idle(3, 1'b0);
      drain();

      send("5a_after_rst", 8'h5A, 1'b0, 1'b0, 1'b0, 2);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 8, payload bits per frame.
REQ-002 SHALL have port: CLK  input  1  bit-rate clock; one frame bit per rising edge.
REQ-003 SHALL have port: RST  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: P_DATA  input  DATA_WIDTH  parallel payload.
REQ-005 SHALL have port: DATA_VALID  input  1  payload request, sampled on rising CLK.
REQ-006 SHALL have port: PAR_EN  input  1  parity bit enable.
REQ-007 SHALL have port: PAR_TYP  input  1  parity type (0 even, 1 odd).
REQ-008 SHALL have port: MUX_SEL  output  3  select for the registered TX output mux.
REQ-009 SHALL have port: SER_DATA  output  1  current serial payload bit.
REQ-010 SHALL have port: PAR_BIT  output  1  computed parity bit.
REQ-011 SHALL have port: BUSY  output  1  frame in progress.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; state register on CLK, MUX_SEL decoded combinationally from state.
REQ-013 SHALL drive MUX_SEL: IDLE 000 (line high), START 001 (0), DATA 010 (SER_DATA), PARITY 011 (PAR_BIT), STOP 100 (1).
REQ-014 SHALL, in IDLE with DATA_VALID=1 at an edge, latch P_DATA, PAR_EN and PAR_TYP and enter START; MUX_SEL=001 in the following cycle.
REQ-015 SHALL hold START, PARITY and STOP for exactly one cycle each; DATA for exactly DATA_WIDTH cycles.
REQ-016 SHALL present payload LSB first on SER_DATA, shifting one bit per DATA cycle; SER_DATA=0 outside DATA.
REQ-017 SHALL compute PAR_BIT at latch time: XOR of payload, inverted when PAR_TYP=1; held stable until next latch.
REQ-018 SHALL go DATA->PARITY when latched PAR_EN=1, else DATA->STOP.
REQ-019 SHALL go STOP->START (back-to-back, new payload latched) if DATA_VALID=1 in STOP, else STOP->IDLE.
REQ-020 SHALL ignore DATA_VALID in START, DATA and PARITY; no request is queued.
REQ-021 SHALL assert BUSY in START, DATA, PARITY, STOP; deassert in IDLE.
REQ-022 SHALL produce frames of DATA_WIDTH+2 cycles without parity, DATA_WIDTH+3 with; the downstream mux adds one cycle of line latency.
REQ-023 SHALL count DATA bits with a counter of width clog2(DATA_WIDTH); wrap never occurs (exit at DATA_WIDTH-1).
REQ-024 SHALL treat PAR_EN/PAR_TYP/P_DATA changes mid-frame as no effect on the current frame.

Reset
REQ-025 SHALL, on RST low at any time including mid-frame, asynchronously force IDLE, MUX_SEL=000, SER_DATA=0, PAR_BIT=0, BUSY=0, shift register and counter cleared.
REQ-026 SHALL, on RST release, require a full new DATA_VALID handshake; aborted frame is never resumed.

Configuration
REQ-027 SHALL use macro UART_TX_PARITY_EN.
REQ-028 SHALL, with UART_TX_PARITY_EN defined, behave per REQ-017/018.
REQ-029 SHALL, without UART_TX_PARITY_EN, omit parity logic: PAR_EN/PAR_TYP ignored, PARITY never entered, PAR_BIT tied 0.

Structure
REQ-030 SHALL take state encoding and MUX_SEL constants (SEL_IDLE, SEL_START, SEL_DATA, SEL_PAR, SEL_STOP) from shared package uart_tx_pkg, also used by the mux.
REQ-031 SHALL instantiate one sub-module uart_tx_serializer (load, shift enable, bit counter, done flag); FSM and parity remain in uart_tx_ctrl.

Verification
REQ-032 SHALL cover: P_DATA=8'hA5, PAR_EN=0 -> MUX_SEL 001, then 010 x8 with SER_DATA 1,0,1,0,0,1,0,1, then 100, then 000; BUSY high 10 cycles.
REQ-033 SHALL cover: P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0 -> PAR_BIT=0, MUX_SEL 011 after the 8th data bit; PAR_TYP=1 -> PAR_BIT=1; BUSY 11 cycles.
REQ-034 SHALL cover: DATA_VALID held high, payloads 8'h01 then 8'hFF -> STOP directly followed by START, no IDLE cycle; second SER_DATA all 1.
REQ-035 SHALL cover: DATA_VALID pulse during DATA with P_DATA=8'h3C -> ignored; frame completes, returns to IDLE, no second frame.
REQ-036 SHALL cover: RST low at 4th DATA cycle -> same-cycle MUX_SEL=000, BUSY=0; after release, 8'h5A request produces a clean full frame.
REQ-037 SHALL cover: build without UART_TX_PARITY_EN, PAR_EN=1 -> no 011 on MUX_SEL, 10-cycle frame, PAR_BIT=0.
